// File: rtl/sha256_compress.sv
// SHA-256 compression core: one round per cycle over a sliding 16-word schedule window,
// accumulating H across the chunks of a message and holding the digest on a ready/valid port.
module sha256_compress (
  input  logic              clk,
  input  logic              rst,
  output logic              chunk_rdy,
  input  logic              chunk_vld,
  input  logic [15:0][31:0] chunk_in,
  input  logic              chunk_first,
  input  logic              chunk_last,
  input  logic              digest_rdy,
  output logic              digest_vld,
  output logic [255:0]      digest,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, ROUND = 2'd1, UPDATE = 2'd2, DONE = 2'd3} state_t;

  // Element 0 is H0 / a; packed concatenation lists the highest index first.
  localparam logic [7:0][31:0] IV = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};

  localparam logic [31:0] K_TAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0000000000, x[31:10]};
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  state_t            state_r;
  logic [7:0][31:0]  hash_r;
  logic [7:0][31:0]  wv_r;
  logic [15:0][31:0] win_r;
  logic [5:0]        t_r;
  logic              last_r;
  logic              chunk_rdy_r;
  logic              digest_vld_r;
  logic              busy_r;

  logic [31:0]       t1_s;
  logic [31:0]       t2_s;
  logic [31:0]       w_new_s;
  logic [7:0][31:0]  wv_next_s;

  // Round datapath: next working variables and next schedule word.
  always_comb begin
    t1_s      = wv_r[7] + bsig1(wv_r[4]) + ch(wv_r[4], wv_r[5], wv_r[6]) + K_TAB[t_r] + win_r[0];
    t2_s      = bsig0(wv_r[0]) + maj(wv_r[0], wv_r[1], wv_r[2]);
    w_new_s   = ssig1(win_r[14]) + win_r[9] + ssig0(win_r[1]) + win_r[0];
    wv_next_s = {wv_r[6:4], wv_r[3] + t1_s, wv_r[2:0], t1_s + t2_s};
  end

  // Control FSM with hash state, window, working vars and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      t_r          <= 6'd0;
      hash_r       <= IV;
      last_r       <= 1'b0;
      chunk_rdy_r  <= 1'b0;
      digest_vld_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          chunk_rdy_r <= 1'b1;
          if (chunk_rdy_r && chunk_vld) begin
            win_r       <= chunk_in;
            wv_r        <= chunk_first ? IV : hash_r;
            if (chunk_first) begin
              hash_r <= IV;
            end
            last_r      <= chunk_last;
            t_r         <= 6'd0;
            state_r     <= ROUND;
            chunk_rdy_r <= 1'b0;
            busy_r      <= 1'b1;
          end
        end
        ROUND: begin
          wv_r  <= wv_next_s;
          win_r <= {w_new_s, win_r[15:1]};
          t_r   <= t_r + 6'd1;
          if (t_r == 6'd63) begin
            state_r <= UPDATE;
          end
        end
        UPDATE: begin
          for (int i = 0; i < 8; i++) begin
            hash_r[i] <= hash_r[i] + wv_r[i];
          end
          if (last_r) begin
            state_r      <= DONE;
            digest_vld_r <= 1'b1;
          end else begin
            state_r     <= IDLE;
            chunk_rdy_r <= 1'b1;
            busy_r      <= 1'b0;
          end
        end
        DONE: begin
          if (digest_vld_r && digest_rdy) begin
            state_r      <= IDLE;
            digest_vld_r <= 1'b0;
            chunk_rdy_r  <= 1'b1;
            busy_r       <= 1'b0;
          end
        end
        default: begin
          state_r      <= IDLE;
          chunk_rdy_r  <= 1'b0;
          digest_vld_r <= 1'b0;
          busy_r       <= 1'b0;
        end
      endcase
    end
  end

  assign chunk_rdy  = chunk_rdy_r;
  assign digest_vld = digest_vld_r;
  assign busy       = busy_r;
  assign digest     = {hash_r[0], hash_r[1], hash_r[2], hash_r[3],
                       hash_r[4], hash_r[5], hash_r[6], hash_r[7]};

endmodule

// File: tb/tb_sha256_compress.sv
// Self-checking bench for sha256_compress: known FIPS vectors, protocol timing,
// and random multi-chunk messages against an array-based SHA-256 reference.
module tb_sha256_compress;

  typedef logic [15:0][31:0] chunk_t;

  localparam logic [255:0] IV_H  = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC_D = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMP_D = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] TWO_D = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  logic         clk = 1'b0;
  logic         rst;
  logic         chunk_rdy;
  logic         chunk_vld;
  chunk_t       chunk_in;
  logic         chunk_first;
  logic         chunk_last;
  logic         digest_rdy;
  logic         digest_vld;
  logic [255:0] digest;
  logic         busy;

  int cyc = 0;
  int vld_cnt = 0;
  int checks = 0;
  int errors = 0;

  sha256_compress dut (
    .clk(clk), .rst(rst), .chunk_rdy(chunk_rdy), .chunk_vld(chunk_vld), .chunk_in(chunk_in),
    .chunk_first(chunk_first), .chunk_last(chunk_last), .digest_rdy(digest_rdy),
    .digest_vld(digest_vld), .digest(digest), .busy(busy));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (digest_vld) vld_cnt <= vld_cnt + 1;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook SHA-256 compression: full 64-entry schedule, then 64 rounds, then add.
  function automatic logic [255:0] ref_compress(input logic [255:0] hin, input chunk_t c);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] hh [8];
    logic [31:0] s0, s1, t1, t2;
    logic [255:0] r;
    for (int i = 0; i < 8; i++) begin
      hh[i] = hin[255 - 32*i -: 32];
      v[i]  = hh[i];
    end
    for (int i = 0; i < 16; i++) w[i] = c[i];
    for (int i = 16; i < 64; i++) begin
      s0 = rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3);
      s1 = rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10);
      w[i] = w[i-16] + s0 + w[i-7] + s1;
    end
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25)) +
           ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
      t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22)) +
           ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = hh[i] + v[i];
    return r;
  endfunction

  function automatic chunk_t rand_chunk();
    chunk_t c;
    for (int i = 0; i < 16; i++) c[i] = $urandom;
    return c;
  endfunction

  // Present a chunk until accepted; acc is the accepting edge, lows the samples with chunk_rdy low.
  task automatic send(input chunk_t c, input bit first, input bit last, input bit hold,
                      output int acc, output int lows);
    bit got = 1'b0;
    bit r;
    lows = 0;
    acc = -1;
    chunk_in = c; chunk_first = first; chunk_last = last; chunk_vld = 1'b1;
    for (int i = 0; i < 400; i++) begin
      r = chunk_rdy;
      @(posedge clk); #1;
      if (r) begin
        acc = cyc;
        got = 1'b1;
        break;
      end
      lows++;
    end
    if (!got) check("accept_timeout", 256'd0, 256'd1);
    if (!hold) begin
      chunk_vld = 1'b0;
      chunk_in = rand_chunk();
      chunk_first = 1'($urandom);
      chunk_last = 1'($urandom);
    end
  endtask

  // Wait for the digest, check value and latency, optionally stall, then complete the handshake.
  task automatic get_digest(input logic [255:0] exp, input string tag, input int acc, input int stall);
    bit found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (digest_vld) begin
        found = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!found) begin
      check({tag, "_timeout"}, 256'd0, 256'd1);
    end else begin
      check(tag, digest, exp);
      // accept at edge N -> UPDATE ends at edge N+65 -> first valid cycle N+66
      if (acc >= 0) check({tag, "_lat"}, 256'(cyc - acc), 256'd65);
      for (int i = 0; i < stall; i++) begin
        @(posedge clk); #1;
        check({tag, "_hold_vld"}, 256'(digest_vld), 256'd1);
        check({tag, "_hold_dig"}, digest, exp);
        check({tag, "_hold_rdy"}, 256'(chunk_rdy), 256'd0);
      end
      digest_rdy = 1'b1;
      @(posedge clk); #1;
      check({tag, "_vld_drop"}, 256'(digest_vld), 256'd0);
      check({tag, "_rdy_back"}, 256'(chunk_rdy), 256'd1);
      check({tag, "_idle"}, 256'(busy), 256'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    chunk_t abc, emp, c1, c2, rc;
    logic [255:0] hm, prev;
    int acc, acc1, acc2, lows, lows2, v0, n, stall;
    bit fst;

    abc = '0; abc[0] = 32'h61626380; abc[15] = 32'h00000018;
    emp = '0; emp[0] = 32'h80000000;
    c1 = '0;
    c1[0] = 32'h61626364; c1[1] = 32'h62636465; c1[2] = 32'h63646566; c1[3] = 32'h64656667;
    c1[4] = 32'h65666768; c1[5] = 32'h66676869; c1[6] = 32'h6768696a; c1[7] = 32'h68696a6b;
    c1[8] = 32'h696a6b6c; c1[9] = 32'h6a6b6c6d; c1[10] = 32'h6b6c6d6e; c1[11] = 32'h6c6d6e6f;
    c1[12] = 32'h6d6e6f70; c1[13] = 32'h6e6f7071; c1[14] = 32'h80000000;
    c2 = '0; c2[15] = 32'h000001c0;

    rst = 1'b1; chunk_vld = 1'b0; chunk_in = '0; chunk_first = 1'b0; chunk_last = 1'b0; digest_rdy = 1'b1;
    @(posedge clk); #1;
    check("rst_chunk_rdy", 256'(chunk_rdy), 256'd0);
    check("rst_digest_vld", 256'(digest_vld), 256'd0);
    check("rst_busy", 256'(busy), 256'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_rdy", 256'(chunk_rdy), 256'd1);
    check("model_abc", ref_compress(IV_H, abc), ABC_D);

    // single-chunk "abc"
    send(abc, 1'b1, 1'b1, 1'b0, acc, lows);
    check("abc_busy", 256'(busy), 256'd1);
    get_digest(ABC_D, "abc", acc, 0);

    // empty message
    send(emp, 1'b1, 1'b1, 1'b0, acc, lows);
    get_digest(EMP_D, "empty", acc, 0);

    // two-chunk message with chunk_vld held between chunks
    v0 = vld_cnt;
    send(c1, 1'b1, 1'b0, 1'b1, acc1, lows);
    send(c2, 1'b0, 1'b1, 1'b0, acc2, lows2);
    check("two_rdy_low", 256'(lows2), 256'd65);
    check("two_spacing", 256'(acc2 - acc1), 256'd66);
    check("two_no_mid_vld", 256'(vld_cnt), 256'(v0));
    get_digest(TWO_D, "two", acc2, 0);

    // backpressure
    digest_rdy = 1'b0;
    send(abc, 1'b1, 1'b1, 1'b0, acc, lows);
    get_digest(ABC_D, "bp", acc, 20);

    // reset during round 30; chunk flagged last so an unaborted run would emit a digest
    v0 = vld_cnt;
    send(c1, 1'b1, 1'b1, 1'b0, acc, lows);
    repeat (30) @(posedge clk);
    #1; rst = 1'b1;
    @(posedge clk); #1;
    check("abort_rdy", 256'(chunk_rdy), 256'd0);
    check("abort_vld", 256'(digest_vld), 256'd0);
    check("abort_busy", 256'(busy), 256'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort_rdy_back", 256'(chunk_rdy), 256'd1);
    repeat (80) @(posedge clk);
    #1;
    check("abort_no_vld", 256'(vld_cnt), 256'(v0));
    send(abc, 1'b1, 1'b1, 1'b0, acc, lows);
    get_digest(ABC_D, "abort_abc", acc, 0);

    // back-to-back messages
    send(abc, 1'b1, 1'b1, 1'b0, acc, lows);
    get_digest(ABC_D, "b2b_abc", acc, 0);
    send(emp, 1'b1, 1'b1, 1'b0, acc, lows);
    get_digest(EMP_D, "b2b_empty", acc, 0);

    // after reset H is the IV, so a continuation chunk hashes like a fresh message
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    send(abc, 1'b0, 1'b1, 1'b0, acc, lows);
    get_digest(ABC_D, "rst_iv_cont", acc, 0);
    prev = ABC_D;

    // random messages, some continuing from the previous H
    for (int m = 0; m < 8; m++) begin
      n = $urandom_range(1, 3);
      fst = (m == 0) || ($urandom_range(0, 3) != 0);
      hm = fst ? IV_H : prev;
      for (int k = 0; k < n; k++) begin
        rc = rand_chunk();
        send(rc, fst && (k == 0), k == n - 1, (k != n - 1) && 1'($urandom), acc, lows);
        hm = ref_compress(hm, rc);
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
      end
      stall = $urandom_range(0, 5);
      digest_rdy = (stall == 0);
      get_digest(hm, "rand", -1, stall);
      prev = hm;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
